// File: rtl/mmc_mdc_p.sv
// LCM (repeated addition of running multiples) or GCD (subtractive Euclid) of two
// unsigned W-bit operands, run as a multi-cycle coprocessor with a start/busy/done handshake.
module mmc_mdc_p #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] res,
  output logic [W-1:0] cycles
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_n;
  logic [W-1:0] a, b, op_a, op_b, k;
  logic [W-1:0] a_n, b_n, op_a_n, op_b_n, k_n, res_n, cycles_n;
  logic         md, md_n, ovf, ovf_n, done_n, err_n;
  logic         a_lt_b, finish;
  logic [W:0]   sum;
  logic [W-1:0] k_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      op_a   <= '0;
      op_b   <= '0;
      k      <= '0;
      md     <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      res    <= '0;
      cycles <= '0;
    end else begin
      state  <= state_n;
      a      <= a_n;
      b      <= b_n;
      op_a   <= op_a_n;
      op_b   <= op_b_n;
      k      <= k_n;
      md     <= md_n;
      ovf    <= ovf_n;
      done   <= done_n;
      err    <= err_n;
      res    <= res_n;
      cycles <= cycles_n;
    end
  end

  assign busy = (state == RUN);

  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    op_a_n   = op_a;
    op_b_n   = op_b;
    k_n      = k;
    md_n     = md;
    ovf_n    = ovf;
    done_n   = 1'b0;
    err_n    = err;
    res_n    = res;
    cycles_n = cycles;
    finish   = 1'b0;

    a_lt_b = (a < b);
    sum    = a_lt_b ? ({1'b0, a} + {1'b0, op_a}) : ({1'b0, b} + {1'b0, op_b});
    k_inc  = (k == '1) ? k : k + 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          a_n      = i_a;
          b_n      = i_b;
          op_a_n   = i_a;
          op_b_n   = i_b;
          md_n     = mode;
          k_n      = '0;
          ovf_n    = 1'b0;
          err_n    = 1'b0;
          res_n    = '0;
          cycles_n = '0;
          state_n  = RUN;
        end
      end
      RUN: begin
        // An overflowing step is recorded and reported on the following cycle.
        if (ovf) begin
          err_n  = 1'b1;
          res_n  = '0;
          finish = 1'b1;
        end else if (a == '0 || b == '0) begin
          res_n  = md ? (a | b) : '0;
          finish = 1'b1;
        end else if (a == b) begin
          res_n  = a;
          finish = 1'b1;
        end else if (!md) begin
          if (sum[W]) begin
            ovf_n = 1'b1;
          end else begin
            if (a_lt_b) a_n = sum[W-1:0];
            else        b_n = sum[W-1:0];
            k_n = k_inc;
          end
        end else begin
          if (a_lt_b) b_n = b - a;
          else        a_n = a - b;
          k_n = k_inc;
        end
        if (finish) begin
          done_n   = 1'b1;
          cycles_n = k;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmc_mdc_p.sv
// Scoreboard bench for mmc_mdc_p: a W=32 instance driven through a result queue,
// plus a W=8 instance for the overflow and long-run cases.
module tb_mmc_mdc_p;

  logic        clk, rst_n;
  logic        start, mode, busy, done, err;
  logic [31:0] i_a, i_b, res, cycles;
  logic        start8, mode8, busy8, done8, err8;
  logic [7:0]  i_a8, i_b8, res8, cycles8;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic [31:0] cyc;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;

  mmc_mdc_p #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .i_a(i_a), .i_b(i_b),
    .busy(busy), .done(done), .err(err), .res(res), .cycles(cycles)
  );

  mmc_mdc_p #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .i_a(i_a8), .i_b(i_b8),
    .busy(busy8), .done(done8), .err(err8), .res(res8), .cycles(cycles8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        last = exp_q.pop_front();
        chk("res", res, last.res);
        chk("err", err, last.err);
        chk("cycles", cycles, last.cyc);
        chk("latency", cyc_cnt - last.acc, last.lat);
        chk("busy_at_done", busy, 1'b0);
      end
    end
  end

  // Assumes the caller is away from the clock edge with busy low.
  task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee, input logic [31:0] ec,
                       input int lat);
    exp_t e;
    mode  = m;
    i_a   = a;
    i_b   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.res = er; e.err = ee; e.cyc = ec; e.lat = lat; e.acc = cyc_cnt;
    exp_q.push_back(e);
    start = 1'b0;
    mode  = ~m;
    i_a   = $urandom;
    i_b   = $urandom;
    chk("busy_after_accept", busy, 1'b1);
    chk("res_cleared", res, 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run8(input logic m, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic ee, input logic [7:0] ec,
                      input int lat);
    int acc;
    int n = 0;
    mode8  = m;
    i_a8   = a;
    i_b8   = b;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    acc    = cyc_cnt;
    start8 = 1'b0;
    @(negedge clk);
    while (!done8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("w8_done_seen", done8, 1'b1);
    chk("w8_latency", cyc_cnt - acc, lat);
    chk("w8_res", res8, er);
    chk("w8_err", err8, ee);
    chk("w8_cycles", cycles8, ec);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0; mode  = 1'b0; i_a  = '0; i_b  = '0;
    start8 = 1'b0; mode8 = 1'b0; i_a8 = '0; i_b8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_res", res, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // W=8: first MMC step overflows; long MMC run of 254 unit steps
    run8(1'b0, 8'd200, 8'd201, 8'd0, 1'b1, 8'd0, 2);
    @(negedge clk);
    run8(1'b0, 8'd1, 8'd255, 8'd255, 1'b0, 8'd254, 255);
    @(negedge clk);

    issue(1'b0, 32'd4, 32'd6, 32'd12, 1'b0, 32'd3, 4);   wait_done();
    @(negedge clk);
    chk("res_held", res, 32'd12);
    chk("cycles_held", cycles, 32'd3);
    issue(1'b1, 32'd48, 32'd18, 32'd6, 1'b0, 32'd4, 5); wait_done();
    @(negedge clk);
    issue(1'b1, 32'd0, 32'd9, 32'd9, 1'b0, 32'd0, 1);   wait_done();
    @(negedge clk);
    issue(1'b0, 32'd0, 32'd9, 32'd0, 1'b0, 32'd0, 1);   wait_done();
    @(negedge clk);
    issue(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1);   wait_done();
    @(negedge clk);
    issue(1'b0, 32'd7, 32'd7, 32'd7, 1'b0, 32'd0, 1);   wait_done();
    @(negedge clk);
    issue(1'b0, 32'd3, 32'd5, 32'd15, 1'b0, 32'd6, 7);  wait_done();
    @(negedge clk);
    issue(1'b1, 32'd17, 32'd5, 32'd1, 1'b0, 32'd6, 7);  wait_done();
    @(negedge clk);
    issue(1'b0, 32'hC000_0000, 32'hC000_0001, 32'd0, 1'b1, 32'd0, 2); wait_done();
    @(negedge clk);

    // start while busy is ignored
    issue(1'b0, 32'd4, 32'd6, 32'd12, 1'b0, 32'd3, 4);
    @(negedge clk);
    mode = 1'b1; i_a = 32'd100; i_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // back-to-back: new start on the done cycle
    issue(1'b1, 32'd48, 32'd18, 32'd6, 1'b0, 32'd4, 5);
    @(negedge clk);
    chk("busy_mid", busy, 1'b1);
    while (!done && exp_q.size() != 0) @(negedge clk);
    issue(1'b0, 32'd7, 32'd7, 32'd7, 1'b0, 32'd0, 1);
    wait_done();
    @(negedge clk);

    // reset during MMC(4,6) step 2
    issue(1'b0, 32'd4, 32'd6, 32'd12, 1'b0, 32'd3, 4);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_res", res, 32'd0);
    chk("abort_cycles", cycles, 32'd0);
    chk("abort_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(1'b1, 32'd48, 32'd18, 32'd6, 1'b0, 32'd4, 5); wait_done();
    repeat (3) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
